// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts a W-bit word on a valid/ready handshake and
// shifts it out one bit per clock, optionally followed by a fixed idle gap.
module bit_serializer #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0,
    parameter logic        IDLE_LVL  = 1'b0
) (
    input  logic         c,
    input  logic         r,
    input  logic [W-1:0] din,
    input  logic         ld,
    output logic         rdy,
    output logic         x,
    output logic         xv,
    output logic         last,
    output logic         busy
);

    localparam int unsigned    CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  CNT_PEN  = CW'(W - 2);
    localparam logic [3:0]     GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic           HAS_GAP  = (GAP > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [3:0]    gap_r, gap_nx;
    logic [W-1:0]  sh_r, sh_nx;
    logic          x_r, x_nx;
    logic          xv_r, xv_nx;
    logic          last_r, last_nx;
    logic          busy_r;
    logic          rdy_s;
    logic          accept_s;

    // Bit that leaves the word first in the configured shift order.
    function automatic logic first_bit(input logic [W-1:0] v);
        if (MSB_FIRST) begin
            first_bit = v[W-1];
        end else begin
            first_bit = v[0];
        end
    endfunction

    // Move the next bit to be sent into the outgoing position.
    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        if (MSB_FIRST) begin
            advance = {v[W-2:0], 1'b0};
        end else begin
            advance = {1'b0, v[W-1:1]};
        end
    endfunction

    // Ready in IDLE, or in the final bit cycle when words may run back to back.
    always_comb begin
        rdy_s    = (state_r == ST_IDLE) ||
                   ((state_r == ST_SHIFT) && last_r && !HAS_GAP);
        accept_s = ld && rdy_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        gap_nx   = gap_r;
        sh_nx    = sh_r;
        x_nx     = IDLE_LVL;
        xv_nx    = 1'b0;
        last_nx  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx = ST_SHIFT;
                    cnt_nx   = {CW{1'b0}};
                    x_nx     = first_bit(din);
                    sh_nx    = advance(din);
                    xv_nx    = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_r) begin
                    if (accept_s) begin
                        state_nx = ST_SHIFT;
                        cnt_nx   = {CW{1'b0}};
                        x_nx     = first_bit(din);
                        sh_nx    = advance(din);
                        xv_nx    = 1'b1;
                    end else if (HAS_GAP) begin
                        state_nx = ST_GAP;
                        gap_nx   = 4'd0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    x_nx    = first_bit(sh_r);
                    sh_nx   = advance(sh_r);
                    xv_nx   = 1'b1;
                    last_nx = (cnt_r == CNT_PEN);
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_nx = ST_IDLE;
                    gap_nx   = 4'd0;
                end else begin
                    gap_nx   = gap_r + 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CW{1'b0}};
                gap_nx   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight word.
    always_ff @(posedge c) begin
        if (!r) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            gap_r   <= 4'd0;
            sh_r    <= {W{1'b0}};
            x_r     <= IDLE_LVL;
            xv_r    <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            gap_r   <= gap_nx;
            sh_r    <= sh_nx;
            x_r     <= x_nx;
            xv_r    <= xv_nx;
            last_r  <= last_nx;
            busy_r  <= (state_nx != ST_IDLE);
        end
    end

    assign rdy  = rdy_s;
    assign x    = x_r;
    assign xv   = xv_r;
    assign last = last_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: three instances cover
// MSB-first, LSB-first and gap-insertion configurations.
module tb_bit_serializer;

    logic       c;
    logic       r;
    logic [7:0] din;
    logic       ld_m, ld_l, ld_g;
    logic       rdy_m, x_m, xv_m, last_m, busy_m;
    logic       rdy_l, x_l, xv_l, last_l, busy_l;
    logic       rdy_g, x_g, xv_g, last_g, busy_g;

    int checks;
    int failures;

    bit_serializer #(.W(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LVL(1'b0)) dut_m (
        .c(c), .r(r), .din(din), .ld(ld_m), .rdy(rdy_m),
        .x(x_m), .xv(xv_m), .last(last_m), .busy(busy_m)
    );

    bit_serializer #(.W(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_LVL(1'b0)) dut_l (
        .c(c), .r(r), .din(din), .ld(ld_l), .rdy(rdy_l),
        .x(x_l), .xv(xv_l), .last(last_l), .busy(busy_l)
    );

    bit_serializer #(.W(8), .MSB_FIRST(1'b1), .GAP(3), .IDLE_LVL(1'b0)) dut_g (
        .c(c), .r(r), .din(din), .ld(ld_g), .rdy(rdy_g),
        .x(x_g), .xv(xv_g), .last(last_g), .busy(busy_g)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic test_reset();
        r    = 1'b0;
        ld_m = 1'b1;
        din  = 8'hAA;
        tick();
        tick();
        checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_m: got x/xv/last/busy/rdy=%b want 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
        checks++;
        if ({x_l, xv_l, last_l, busy_l, rdy_l} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_l: got %b want 00001", {x_l, xv_l, last_l, busy_l, rdy_l});
        end
        checks++;
        if ({x_g, xv_g, last_g, busy_g, rdy_g} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_g: got %b want 00001", {x_g, xv_g, last_g, busy_g, rdy_g});
        end
        ld_m = 1'b0;
        r    = 1'b1;
        tick();
        checks++;
        if ({busy_m, xv_m} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ld_ignored: got busy/xv=%b want 00", {busy_m, xv_m});
        end
    endtask

    task automatic test_msb_single();
        logic [7:0] seq;
        seq  = 8'b1010_0101;
        din  = 8'hA5;
        ld_m = 1'b1;
        tick();
        ld_m = 1'b0;
        din  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== {seq[7-i], 1'b1, (i == 7), 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL msb_single bit%0d: got x/xv/last/busy/rdy=%b want %b", i + 1,
                         {x_m, xv_m, last_m, busy_m, rdy_m}, {seq[7-i], 1'b1, (i == 7), 1'b1, (i == 7)});
            end
            tick();
        end
        checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            failures++;
            $display("FAIL msb_single_idle: got %b want 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
    endtask

    task automatic test_lsb();
        logic [7:0] words [2];
        logic [7:0] seqs  [2];
        words[0] = 8'hA5;
        seqs[0]  = 8'b1010_0101;
        words[1] = 8'h01;
        seqs[1]  = 8'b1000_0000;
        for (int w = 0; w < 2; w++) begin
            din  = words[w];
            ld_l = 1'b1;
            tick();
            ld_l = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({x_l, xv_l, last_l} !== {seqs[w][7-i], 1'b1, (i == 7)}) begin
                    failures++;
                    $display("FAIL lsb word%0d bit%0d: got x/xv/last=%b want %b", w, i + 1,
                             {x_l, xv_l, last_l}, {seqs[w][7-i], 1'b1, (i == 7)});
                end
                tick();
            end
            checks++;
            if ({xv_l, busy_l} !== 2'b00) begin
                failures++;
                $display("FAIL lsb_idle word%0d: got xv/busy=%b want 00", w, {xv_l, busy_l});
            end
        end
    endtask

    task automatic test_back_to_back();
        din  = 8'hFF;
        ld_m = 1'b1;
        tick();
        din  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({x_m, xv_m, last_m} !== {(i < 8), 1'b1, (i == 7 || i == 15)}) begin
                failures++;
                $display("FAIL back_to_back cyc%0d: got x/xv/last=%b want %b", i + 1,
                         {x_m, xv_m, last_m}, {(i < 8), 1'b1, (i == 7 || i == 15)});
            end
            if (i == 8) begin
                ld_m = 1'b0;
            end
            tick();
        end
        checks++;
        if ({xv_m, busy_m, rdy_m} !== 3'b001) begin
            failures++;
            $display("FAIL back_to_back_end: got xv/busy/rdy=%b want 001", {xv_m, busy_m, rdy_m});
        end
    endtask

    task automatic test_gap();
        logic [7:0] seq;
        seq  = 8'b1000_0001;
        din  = 8'h81;
        ld_g = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({x_g, xv_g, last_g, rdy_g} !== {seq[7-i], 1'b1, (i == 7), 1'b0}) begin
                failures++;
                $display("FAIL gap_word bit%0d: got x/xv/last/rdy=%b want %b", i + 1,
                         {x_g, xv_g, last_g, rdy_g}, {seq[7-i], 1'b1, (i == 7), 1'b0});
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({x_g, xv_g, last_g, rdy_g, busy_g} !== 5'b00001) begin
                failures++;
                $display("FAIL gap_idle cyc%0d: got x/xv/last/rdy/busy=%b want 00001", i + 1,
                         {x_g, xv_g, last_g, rdy_g, busy_g});
            end
            tick();
        end
        checks++;
        if ({xv_g, rdy_g, busy_g} !== 3'b010) begin
            failures++;
            $display("FAIL gap_then_idle: got xv/rdy/busy=%b want 010", {xv_g, rdy_g, busy_g});
        end
        tick();
        ld_g = 1'b0;
        checks++;
        if ({x_g, xv_g, busy_g} !== 3'b111) begin
            failures++;
            $display("FAIL gap_second_word: got x/xv/busy=%b want 111", {x_g, xv_g, busy_g});
        end
        repeat (11) tick();
        checks++;
        if ({busy_g, rdy_g} !== 2'b01) begin
            failures++;
            $display("FAIL gap_drain: got busy/rdy=%b want 01", {busy_g, rdy_g});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] seq;
        din  = 8'hF0;
        ld_m = 1'b1;
        tick();
        ld_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({x_m, xv_m} !== 2'b11) begin
                failures++;
                $display("FAIL reset_mid_pre bit%0d: got x/xv=%b want 11", i + 1, {x_m, xv_m});
            end
            if (i == 2) begin
                r = 1'b0;
            end
            tick();
        end
        checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_mid_flush: got x/xv/last/busy/rdy=%b want 00001",
                     {x_m, xv_m, last_m, busy_m, rdy_m});
        end
        r    = 1'b1;
        tick();
        seq  = 8'b0000_1111;
        din  = 8'h0F;
        ld_m = 1'b1;
        tick();
        ld_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({x_m, xv_m, last_m} !== {seq[7-i], 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL reset_mid_new bit%0d: got x/xv/last=%b want %b", i + 1,
                         {x_m, xv_m, last_m}, {seq[7-i], 1'b1, (i == 7)});
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] seq;
        seq  = 8'b1100_0011;
        din  = 8'hC3;
        ld_m = 1'b1;
        tick();
        ld_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({x_m, xv_m, last_m} !== {seq[7-i], 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL busy_ignore bit%0d: got x/xv/last=%b want %b", i + 1,
                         {x_m, xv_m, last_m}, {seq[7-i], 1'b1, (i == 7)});
            end
            if (i == 2) begin
                din  = 8'h3C;
                ld_m = 1'b1;
            end else begin
                ld_m = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({xv_m, busy_m} !== 2'b00) begin
                failures++;
                $display("FAIL busy_ignore_not_queued cyc%0d: got xv/busy=%b want 00", i + 1, {xv_m, busy_m});
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        r        = 1'b0;
        din      = 8'h00;
        ld_m     = 1'b0;
        ld_l     = 1'b0;
        ld_g     = 1'b0;
        #1;
        test_reset();
        test_msb_single();
        test_lsb();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
